// File: rtl/fp_display_sel.sv
// Front-panel display selector.
// Picks one of NCH W-bit channels for the panel data lamps, drives the
// one-hot channel indicator LEDs and the RUN lamp. The channel index is
// stepped manually (sel_up/sel_dn, wrapping both ways) or advanced by an
// auto-scan timer with a programmable dwell. Freeze holds the displayed
// data while the index keeps following manual steps. All outputs are registered.
module fp_display_sel #(
    parameter int W     = 12,
    parameter int NCH   = 6,
    parameter int DWELL = 1000000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NCH*W-1:0]                      din,
    input  logic                                  sel_up,
    input  logic                                  sel_dn,
    input  logic                                  scan_en,
    input  logic                                  freeze,
    input  logic                                  run_ff,
    input  logic                                  sw_active,
    output logic [W-1:0]                          dout,
    output logic [((NCH > 2) ? $clog2(NCH) : 1)-1:0] dsel,
    output logic [NCH-1:0]                        dsel_led,
    output logic                                  run_led,
    output logic                                  scan_tick
);

    localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1;
    localparam int CW   = (DWELL > 2) ? $clog2(DWELL) : 1;

    localparam logic [SELW-1:0] IDX_LAST = SELW'(NCH - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

    // Registered state
    logic [SELW-1:0] idx_q, idx_d;
    logic [NCH-1:0]  led_q, led_d;
    logic [W-1:0]    dout_q, dout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick_q, tick_d;
    logic            run_q, run_d;

    // Decoded controls
    logic            up_only;
    logic            dn_only;
    logic            both_sel;
    logic            term_cnt;
    logic [SELW-1:0] idx_inc;
    logic [SELW-1:0] idx_dec;
    logic [W-1:0]    chan_data;

    // Step decode, terminal count and wrapped neighbour indices
    always_comb begin
        up_only  = sel_up & ~sel_dn;
        dn_only  = sel_dn & ~sel_up;
        both_sel = sel_up & sel_dn;
        term_cnt = scan_en & ~freeze & (cnt_q == CNT_LAST);
        // Explicit wrap compares keep the index below NCH even when NCH is
        // not a power of two.
        idx_inc  = (idx_q == IDX_LAST) ? '0 : idx_q + SELW'(1);
        idx_dec  = (idx_q == '0) ? IDX_LAST : idx_q - SELW'(1);
    end

    // Dwell counter next state: manual steps restart the dwell, freeze pauses it
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the block leaves it unassigned (which would infer a latch).
        cnt_d = cnt_q;
        if (!scan_en) begin
            cnt_d = '0;
        end else if (up_only || dn_only) begin
            cnt_d = '0;
        end else if (freeze || both_sel) begin
            cnt_d = cnt_q;
        end else if (term_cnt) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Next index in priority order: both steps, up, down, scan advance, hold
    always_comb begin
        idx_d  = idx_q;
        tick_d = 1'b0;
        if (both_sel) begin
            idx_d = idx_q;
        end else if (up_only) begin
            idx_d = idx_inc;
        end else if (dn_only) begin
            idx_d = idx_dec;
        end else if (term_cnt) begin
            idx_d  = idx_inc;
            tick_d = 1'b1;
        end
    end

    // Channel mux and one-hot decode, both driven by the next index so the
    // data and indicators change on the same edge as dsel
    always_comb begin
        chan_data = '0;
        led_d     = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx_d == SELW'(k)) begin
                chan_data = din[k*W +: W];
                led_d[k]  = 1'b1;
            end
        end
        dout_d = freeze ? dout_q : chan_data;
        run_d  = run_ff ^ sw_active;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            led_q  <= NCH'(1);
            dout_q <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            idx_q  <= idx_d;
            led_q  <= led_d;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            run_q  <= run_d;
        end
    end

    assign dsel      = idx_q;
    assign dsel_led  = led_q;
    assign dout      = dout_q;
    assign run_led   = run_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_fp_display_sel.sv
// Directed bench for fp_display_sel with W=12, NCH=6, DWELL=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_fp_display_sel;

    localparam int W     = 12;
    localparam int NCH   = 6;
    localparam int DWELL = 4;
    localparam int SELW  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*W-1:0]  din;
    logic              sel_up, sel_dn, scan_en, freeze, run_ff, sw_active;
    logic [W-1:0]      dout;
    logic [SELW-1:0]   dsel;
    logic [NCH-1:0]    dsel_led;
    logic              run_led, scan_tick;

    logic [W-1:0] ch [NCH];

    int n_cmp = 0;
    int n_bad = 0;

    fp_display_sel #(.W(W), .NCH(NCH), .DWELL(DWELL)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .sel_up   (sel_up),
        .sel_dn   (sel_dn),
        .scan_en  (scan_en),
        .freeze   (freeze),
        .run_ff   (run_ff),
        .sw_active(sw_active),
        .dout     (dout),
        .dsel     (dsel),
        .dsel_led (dsel_led),
        .run_led  (run_led),
        .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    task automatic pack_din();
        for (int k = 0; k < NCH; k++) din[k*W +: W] = ch[k];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic up, input logic dn);
        sel_up = up;
        sel_dn = dn;
        step();
        sel_up = 1'b0;
        sel_dn = 1'b0;
    endtask

    task automatic cmp(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0o (octal) expected %0o (octal)", name, got, exp);
        end
    endtask

    task automatic test_reset();
        // Reset asserted from time 0
        #1;
        cmp("rst0_dsel", int'(dsel), 0);
        cmp("rst0_led", int'(dsel_led), 6'b000001);
        cmp("rst0_dout", int'(dout), 0);
        cmp("rst0_run", int'(run_led), 0);
        cmp("rst0_tick", int'(scan_tick), 0);
        step();
        reset = 1'b0;
        step();
        cmp("post_rst_dout", int'(dout), 12'o1000);
        pulse(1, 0);
        pulse(1, 0);
        pulse(1, 0);
        cmp("pre_rst_dsel", int'(dsel), 3);
        cmp("pre_rst_dout", int'(dout), 12'o1003);
        // Mid-cycle reset must act without a clock edge
        #2;
        reset = 1'b1;
        #1;
        cmp("midrst_dsel", int'(dsel), 0);
        cmp("midrst_led", int'(dsel_led), 6'b000001);
        cmp("midrst_dout", int'(dout), 0);
        cmp("midrst_tick", int'(scan_tick), 0);
        reset = 1'b0;
        step();
        cmp("rel_dout", int'(dout), 12'o1000);
        cmp("rel_dsel", int'(dsel), 0);
    endtask

    task automatic test_wrap();
        pulse(0, 1);
        cmp("wrap_dn_dsel", int'(dsel), 5);
        cmp("wrap_dn_led", int'(dsel_led), 6'b100000);
        cmp("wrap_dn_dout", int'(dout), 12'o1005);
        pulse(1, 0);
        cmp("wrap_up_dsel", int'(dsel), 0);
        cmp("wrap_up_led", int'(dsel_led), 6'b000001);
        cmp("wrap_up_dout", int'(dout), 12'o1000);
    endtask

    task automatic test_both();
        pulse(1, 0);
        pulse(1, 0);
        pulse(1, 1);
        cmp("both_dsel", int'(dsel), 2);
        cmp("both_led", int'(dsel_led), 6'b000100);
        cmp("both_dout", int'(dout), 12'o1002);
    endtask

    task automatic test_scan();
        int exp_idx;
        pulse(1, 0);
        pulse(1, 0);
        cmp("scan_start", int'(dsel), 4);
        scan_en = 1'b1;
        exp_idx = 4;
        // Ticks expected on cycles 4, 8, 12 -> dsel 5, 0, 1
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c % 4 == 0) exp_idx = (exp_idx + 1) % NCH;
            cmp($sformatf("scan_tick_c%0d", c), int'(scan_tick), (c % 4 == 0) ? 1 : 0);
            cmp($sformatf("scan_dsel_c%0d", c), int'(dsel), exp_idx);
        end
        cmp("scan_dout", int'(dout), 12'o1001);
        // Cycles 13..15 count up to the terminal value
        for (int c = 13; c <= 15; c++) begin
            step();
            cmp($sformatf("scan_tick_c%0d", c), int'(scan_tick), 0);
        end
        // Manual step lands on the terminal-count edge
        pulse(1, 0);
        cmp("coll_dsel", int'(dsel), 2);
        cmp("coll_tick", int'(scan_tick), 0);
        for (int c = 17; c <= 19; c++) begin
            step();
            cmp($sformatf("post_coll_tick_c%0d", c), int'(scan_tick), 0);
            cmp($sformatf("post_coll_dsel_c%0d", c), int'(dsel), 2);
        end
        step();
        cmp("next_tick", int'(scan_tick), 1);
        cmp("next_tick_dsel", int'(dsel), 3);
        scan_en = 1'b0;
        step();
        cmp("scan_off_tick", int'(scan_tick), 0);
    endtask

    task automatic test_freeze();
        pulse(0, 1);
        cmp("frz_idx", int'(dsel), 2);
        ch[2] = 12'o1234;
        pack_din();
        step();
        cmp("frz_din_lat", int'(dout), 12'o1234);
        freeze = 1'b1;
        ch[2] = 12'o4321;
        pack_din();
        step();
        cmp("frz_hold", int'(dout), 12'o1234);
        pulse(1, 0);
        cmp("frz_step_dsel", int'(dsel), 3);
        cmp("frz_step_led", int'(dsel_led), 6'b001000);
        cmp("frz_step_dout", int'(dout), 12'o1234);
        freeze = 1'b0;
        step();
        cmp("frz_release", int'(dout), 12'o1003);
        ch[2] = 12'o1002;
        pack_din();
    endtask

    task automatic test_run();
        logic [1:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            run_ff    = v[1];
            sw_active = v[0];
            step();
            cmp($sformatf("run_led_%0d%0d", v[1], v[0]), int'(run_led), (i == 1 || i == 2) ? 1 : 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        sel_up = 1'b0; sel_dn = 1'b0; scan_en = 1'b0; freeze = 1'b0;
        run_ff = 1'b0; sw_active = 1'b0;
        for (int k = 0; k < NCH; k++) ch[k] = 12'(12'o1000 + k);
        pack_din();
        test_reset();
        test_wrap();
        test_both();
        test_scan();
        test_freeze();
        test_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
